// File: rtl/tile_addr_gen_pkg.sv
// tile_addr_gen_pkg: shared FSM state type and default widths for the tile address generator.
package tile_addr_gen_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  localparam int ADDR_W_DEF = 16;
  localparam int DIM_W_DEF  = 8;
endpackage

// File: rtl/tile_addr_gen_if.sv
// tile_addr_gen_if: tile config/start request plus the valid/ready address stream.
interface tile_addr_gen_if
  import tile_addr_gen_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DIM_W  = DIM_W_DEF
);
  logic              start;
  logic [DIM_W-1:0]  rows;
  logic [DIM_W-1:0]  cols;
  logic [ADDR_W-1:0] base;
  logic [ADDR_W-1:0] stride;
  logic              addr_ready;
  logic              addr_valid;
  logic [ADDR_W-1:0] addr;
  logic [DIM_W-1:0]  row_idx;
  logic [DIM_W-1:0]  col_idx;
  logic              last;
  logic              busy;
  logic              done;
  modport master (
    output start, rows, cols, base, stride, addr_ready,
    input  addr_valid, addr, row_idx, col_idx, last, busy, done
  );
  modport slave (
    input  start, rows, cols, base, stride, addr_ready,
    output addr_valid, addr, row_idx, col_idx, last, busy, done
  );
endinterface

// File: rtl/tile_addr_gen_loop_counter.sv
// loop_counter: wrapping 0..max_val counter with priority clear.
module loop_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         clear,
  input  logic         enable,
  input  logic [W-1:0] max_val,
  output logic [W-1:0] count,
  output logic         at_max
);
  logic [W-1:0] r_count;
  assign count  = r_count;
  assign at_max = r_count == max_val;
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)       r_count <= '0;
    else if (clear)  r_count <= '0;
    else if (enable) r_count <= at_max ? '0 : r_count + W'(1);
  end
endmodule

// File: rtl/tile_addr_gen.sv
// tile_addr_gen: nested row/column walker emitting base + row*stride + col, one address per handshake.
module tile_addr_gen
  import tile_addr_gen_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DIM_W  = DIM_W_DEF
) (
  input  logic           clk,
  input  logic           rstn,
  tile_addr_gen_if.slave bus
);
  state_t            r_state, w_next;
  logic [DIM_W-1:0]  r_rows, r_cols, w_row, w_col;
  logic [ADDR_W-1:0] r_stride, r_row_base;
  logic              w_accept, w_zero, w_run, w_hs, w_col_max, w_row_max, w_last;
  assign w_run    = r_state == RUN;
  assign w_accept = r_state == IDLE && bus.start;
  assign w_zero   = bus.rows == '0 || bus.cols == '0;
  assign w_hs     = w_run && bus.addr_ready;
  assign w_last   = w_run && w_col_max && w_row_max;
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_state <= IDLE;
    else       r_state <= w_next;
  end
  always_comb begin
    w_next = r_state;
    if (w_accept)               w_next = w_zero ? DONE : RUN;
    else if (w_hs && w_last)    w_next = DONE;
    else if (r_state == DONE)   w_next = IDLE;
  end
  // row_base accumulates the stride so the address needs only an adder
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_rows     <= '0;
      r_cols     <= '0;
      r_stride   <= '0;
      r_row_base <= '0;
    end else if (w_accept && !w_zero) begin
      r_rows     <= bus.rows;
      r_cols     <= bus.cols;
      r_stride   <= bus.stride;
      r_row_base <= bus.base;
    end else if (w_hs && w_col_max && !w_row_max) begin
      r_row_base <= r_row_base + r_stride;
    end
  end
  loop_counter #(.W(DIM_W)) u_col (
    .clk(clk), .rstn(rstn), .clear(w_accept), .enable(w_hs),
    .max_val(r_cols - DIM_W'(1)), .count(w_col), .at_max(w_col_max)
  );
  loop_counter #(.W(DIM_W)) u_row (
    .clk(clk), .rstn(rstn), .clear(w_accept), .enable(w_hs && w_col_max),
    .max_val(r_rows - DIM_W'(1)), .count(w_row), .at_max(w_row_max)
  );
  assign bus.addr_valid = w_run;
  assign bus.addr       = w_run ? r_row_base + ADDR_W'(w_col) : '0;
  assign bus.row_idx    = w_run ? w_row : '0;
  assign bus.col_idx    = w_run ? w_col : '0;
  assign bus.last       = w_last;
  assign bus.busy       = r_state != IDLE;
  assign bus.done       = r_state == DONE;
endmodule

// File: doc/tile_addr_gen.md
# tile_addr_gen

Nested-loop address generator that drives the read port of a TPU operand buffer, one address per handshake, for a rows × cols tile. It is the stage fed by the loop-counter pair. An inner counter walks columns, an outer counter walks rows, and the block converts the two counts into linear buffer addresses with a runtime base and row stride. Downstream, the buffer read/feeder stage consumes the address stream through a valid/ready handshake.

## Interface
- ADDR_W, 16, width of base, stride and address
- DIM_W, 8, width of rows/cols and the row/column indices
- clk  in  1  clock, all state on rising edge
- rstn  in  1  asynchronous active-low reset
- start  in  1  one-cycle request; sampled only in IDLE
- rows  in  DIM_W  tile row count; latched on accepted start
- cols  in  DIM_W  tile column count; latched on accepted start
- base  in  ADDR_W  address of element (0,0); latched on accepted start
- stride  in  ADDR_W  address distance between rows; latched on accepted start
- addr_ready  in  1  downstream accepts the current address
- addr_valid  out  1  addr/row_idx/col_idx/last are valid
- addr  out  ADDR_W  base + row·stride + col, modulo 2^ADDR_W
- row_idx  out  DIM_W  current row index
- col_idx  out  DIM_W  current column index
- last  out  1  current address is the final one of the tile
- busy  out  1  state ≠ IDLE
- done  out  1  one-cycle pulse, tile finished

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE, start=1, rows≠0 and cols≠0: latch rows, cols, base and stride; set row_base=base, row=0, col=0; go to RUN.
- IDLE, start=1, rows=0 or cols=0: go to DONE without issuing any address.
- RUN: addr_valid=1. A handshake occurs when addr_valid && addr_ready.
  - On a handshake with col < cols−1: col+1.
  - On a handshake with col = cols−1 and row < rows−1: col=0, row+1, row_base += stride.
  - On a handshake with last=1: go to DONE.
  - With no handshake, all outputs hold stable.
- addr = row_base + col, zero-extended col, truncated to ADDR_W. Wrap-around is legal and silent. No multiplier is used.
- last = (row = rows−1) && (col = cols−1), qualified by addr_valid.
- DONE: done=1 for exactly one cycle, then IDLE.
- start outside IDLE is ignored. In-flight config does not change.
- Config inputs are don't-care except in the cycle start is accepted.
- Reset, including mid-tile: state=IDLE and every output 0 (addr_valid, addr, row_idx, col_idx, last, busy, done). Latched config is cleared to 0. Any partial tile is abandoned; there is no resume.

## Timing
- All outputs are registered or decoded from registered state; there is no combinational path from addr_ready to any output.
- start accepted in cycle N → busy=1 and addr_valid=1 with addr=base from cycle N+1.
- Full throughput: with addr_ready held at 1, one address per cycle, rows·cols addresses in cycles N+1 … N+rows·cols.
- Final handshake in cycle M → done=1, busy=1, addr_valid=0 in cycle M+1 → IDLE in cycle M+2. A new start is accepted in M+2.
- Zero-dimension start in cycle N → done=1 in N+1, IDLE in N+2, addr_valid never asserted.
- Row advance and the row_base update happen on the same edge; the address after a row wrap is correct in the next cycle with no bubble.

## Structure
- Package tile_addr_gen_pkg:
  - state enum {IDLE, RUN, DONE}
  - default ADDR_W/DIM_W localparams
- Sub-module loop_counter, instantiated twice (col = inner, row = outer):
  - ports: clk, rstn, clear, enable, max_val, count, at_max
  - behaviour: count resets to 0; clear has priority; enable at count = max_val wraps to 0; at_max = (count = max_val)
  - outer counter enable = inner at_max && handshake
- Top level holds: FSM, config registers, row_base accumulator, output decode.

## Test plan
- rows=2, cols=3, base=0x0100, stride=0x0010, ready=1 → addr 0x0100,0x0101,0x0102,0x0110,0x0111,0x0112 on consecutive cycles; last only on 0x0112; done the next cycle.
- Same tile, ready toggling 1,0,1,0… → identical sequence, each address held stable while ready=0, no skips or duplicates.
- rows=0, cols=5 and rows=3, cols=0 → done one cycle after start; addr_valid never 1.
- start pulsed again mid-tile with different config → ignored; original sequence completes unchanged.
- rows=1, cols=4, base=0xFFFE, stride=1 → 0xFFFE,0xFFFF,0x0000,0x0001.
- rstn low after the 3rd address of a 4×4 tile → all outputs 0 immediately (asynchronous); after release, a new start produces a full correct tile from base.
